// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared widths, stride and fetch FSM encoding
package if_fetch_stage_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;
  localparam logic [ADDRESS_LEN-1:0] WORD_STRIDE = 32'd4;

  typedef enum logic [1:0] {
    FETCH_STATE_IDLE = 2'd0,
    FETCH_STATE_BUSY = 2'd1,
    FETCH_STATE_HELD = 2'd2,
    FETCH_STATE_DROP = 2'd3
  } fetch_state_e;

  function automatic logic [ADDRESS_LEN-1:0] word_align(input logic [ADDRESS_LEN-1:0] addr);
    return {addr[ADDRESS_LEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_register.sv
// rtl/if_fetch_stage_if_id_register.sv - IF/ID pipeline register
// Flush beats load, load beats hold; a flushed entry is all zeros.
module if_id_register
  import if_fetch_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       flush,
  input  logic [ADDRESS_LEN-1:0]     pc_in,
  input  logic [INSTRUCTION_LEN-1:0] instr_in,
  output logic [ADDRESS_LEN-1:0]     pc_out,
  output logic [INSTRUCTION_LEN-1:0] instruction_out,
  output logic                       valid_out
);

  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic [INSTRUCTION_LEN-1:0] instr_q, instr_d;
  logic                       valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush) begin
      pc_d    = '0;
      instr_d = '0;
      valid_d = 1'b0;
    end else if (load) begin
      pc_d    = pc_in;
      instr_d = instr_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out          = pc_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC, imem req/ack FSM, holding buffer
// FETCH_STALL_COUNTER_EN adds the stall_cycles output.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [ADDRESS_LEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDRESS_LEN-1:0]     branch_address,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic                       imem_ack,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic [ADDRESS_LEN-1:0]     pc_out,
  output logic [INSTRUCTION_LEN-1:0] instruction_out,
  output logic                       valid_out
`ifdef FETCH_STALL_COUNTER_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);

  fetch_state_e               state_q, state_d;
  logic [ADDRESS_LEN-1:0]     pc_q, pc_d;
  logic [ADDRESS_LEN-1:0]     req_addr_q, req_addr_d;
  logic [ADDRESS_LEN-1:0]     hold_pc_q, hold_pc_d;
  logic [INSTRUCTION_LEN-1:0] hold_instr_q, hold_instr_d;

  logic                       ifid_load, ifid_flush;
  logic [ADDRESS_LEN-1:0]     ifid_pc;
  logic [INSTRUCTION_LEN-1:0] ifid_instr;
  logic [ADDRESS_LEN-1:0]     target, req_next;

  assign target   = word_align(branch_address);
  assign req_next = req_addr_q + WORD_STRIDE;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;
    ifid_pc      = req_next;
    ifid_instr   = imem_rdata;

    case (state_q)
      FETCH_STATE_IDLE: begin
        state_d    = FETCH_STATE_BUSY;
        req_addr_d = pc_q;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          req_addr_d = target;
        end
      end
      FETCH_STATE_BUSY: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          if (imem_ack) req_addr_d = target;
          else          state_d    = FETCH_STATE_DROP;
        end else if (imem_ack) begin
          pc_d = req_next;
          if (freeze) begin
            hold_pc_d    = req_next;
            hold_instr_d = imem_rdata;
            state_d      = FETCH_STATE_HELD;
          end else begin
            ifid_load  = 1'b1;
            req_addr_d = req_next;
          end
        end else if (!freeze) begin
          ifid_flush = 1'b1;
        end
      end
      FETCH_STATE_HELD: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
          req_addr_d = target;
          state_d    = FETCH_STATE_BUSY;
        end else if (!freeze) begin
          ifid_load  = 1'b1;
          ifid_pc    = hold_pc_q;
          ifid_instr = hold_instr_q;
          req_addr_d = pc_q;
          state_d    = FETCH_STATE_BUSY;
        end
      end
      FETCH_STATE_DROP: begin
        // The in-flight word is stale; only the latest redirect target matters.
        if (branch_taken) begin
          ifid_flush = 1'b1;
          pc_d       = target;
        end
        if (imem_ack) begin
          req_addr_d = branch_taken ? target : pc_q;
          state_d    = FETCH_STATE_BUSY;
        end
      end
      default: state_d = FETCH_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FETCH_STATE_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  assign imem_req  = (state_q == FETCH_STATE_BUSY) || (state_q == FETCH_STATE_DROP);
  assign imem_addr = req_addr_q;

  if_id_register u_if_id_register (
    .clk             (clk),
    .rst             (rst),
    .load            (ifid_load),
    .flush           (ifid_flush),
    .pc_in           (ifid_pc),
    .instr_in        (ifid_instr),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

`ifdef FETCH_STALL_COUNTER_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == FETCH_STATE_BUSY && !imem_ack) ||
        state_q == FETCH_STATE_HELD || state_q == FETCH_STATE_DROP)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule
